mc_main_control: RTL and testbench
==================================

// Module: mc_main_control
// PURPOSE
//  Main control FSM for the multi-cycle MIPS datapath. Sequences each instruction through
//  fetch/decode/execute/memory/writeback. Drives every datapath mux select and write enable,
//  and drives ALUOp to ALUControl.
//  Sits beside ALUControl: receives opcode = IR[31:26]; stalls on a memory ready handshake.
// PARAMETERS
//  OPW       6   opcode width
//  STW       4   state register width (12 states used)
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous active-low reset
//  opcode     in   OPW  IR[31:26], valid from DECODE onward
//  mem_ready  in   1    memory completes the current access this cycle
//  PCWrite    out  1    unconditional PC load
//  Branch     out  1    PC load qualified by ALU zero (beq)
//  IorD       out  1    0 = address from PC, 1 = address from ALUOut
//  MemRead    out  1    memory read request
//  MemWrite   out  1    memory write request
//  IRWrite    out  1    load instruction register
//  MemtoReg   out  1    1 = register write data from MDR
//  RegDst     out  1    1 = rd, 0 = rt
//  RegWrite   out  1    register file write enable
//  ALUSrcA    out  1    0 = PC, 1 = register A
//  ALUSrcB    out  2    00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
//  PCSrc      out  2    00 = ALU result, 01 = ALUOut, 10 = jump target
//  ALUOp      out  2    00 = add, 01 = sub, 10 = funct decode; 11 is never driven
//  state      out  STW  current state, for debug
//  illegal_op out  1    one-cycle pulse in DECODE on an unsupported opcode
// BEHAVIOUR
//  States (encoding):
//    FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7,
//    BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
//  Reset: while rst_n=0, state=FETCH and ALL outputs are forced to 0, including state bits 0.
//    Releasing reset starts FETCH on the next edge. Reset asserted mid-instruction aborts it
//    immediately; no partial write completes after rst_n falls.
//  Outputs are a Moore decode of state. Exception: IRWrite/PCWrite in FETCH are ANDed with
//    mem_ready (Mealy).
//  FETCH:  MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
//          IRWrite=PCWrite=mem_ready.
//          Stay while mem_ready=0; go to DECODE when mem_ready=1.
//  DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precomputed). Next state by opcode:
//          000000 R   -> EXEC
//          100011 lw  -> MEMADR
//          101011 sw  -> MEMADR
//          000100 beq -> BRANCH
//          001000 addi-> ADDIEX
//          000010 j   -> JUMP
//          others     -> FETCH, with illegal_op=1 for this cycle only
//  MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: lw -> MEMRD, sw -> MEMWR.
//  MEMRD:  MemRead=1, IorD=1. Hold until mem_ready, then MEMWB.
//  MEMWB:  RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
//  MEMWR:  MemWrite=1, IorD=1. Hold until mem_ready, then FETCH.
//          MemWrite stays high for the whole wait.
//  EXEC:   ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state ALUWB.
//  ALUWB:  RegWrite=1, RegDst=1, MemtoReg=0. Next state FETCH.
//  BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSrc=01. Next state FETCH.
//  ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state ADDIWB.
//  ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next state FETCH.
//  JUMP:   PCWrite=1, PCSrc=10. Next state FETCH.
//  Unused encodings 12-15: all outputs 0, next state FETCH (self-recovery).
//  opcode is sampled in DECODE and MEMADR only; changes to opcode in other states are ignored.
//  Latency with mem_ready tied high: R=4, lw=5, sw=4, beq=3, addi=4, j=3 cycles.
//    Each mem_ready=0 cycle in a memory state adds 1 cycle.
//  At most one of RegWrite/MemWrite/IRWrite is high in any cycle.
// TESTING
//  1 rst_n=0 for 3 cycles mid-stream -> all outputs 0, state=0; after release, FETCH with MemRead=1.
//  2 mem_ready=1, opcode=000000 -> states 0,1,6,7,0. ALUOp=10 in EXEC; RegWrite=1, RegDst=1 in ALUWB.
//  3 opcode=100011, mem_ready low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0.
//    MemRead/IorD held in MEMRD; RegWrite+MemtoReg in MEMWB.
//  4 opcode=101011 then 000100 then 000010 ->
//    sw: 0,1,2,5,0 with MemWrite only in 5.
//    beq: 0,1,8,0 with ALUOp=01, Branch=1, PCSrc=01.
//    j: 0,1,11,0 with PCWrite=1, PCSrc=10.
//  5 mem_ready=0 in FETCH for 4 cycles -> IRWrite=PCWrite=0 throughout the wait.
//    Both pulse for exactly 1 cycle when mem_ready rises.
//  6 opcode=111111 -> illegal_op=1 in DECODE for one cycle, then FETCH, no write enable asserted.
//    Also force state=13 -> FETCH next cycle.

Source files
------------

// File: rtl/mc_main_control.sv
// rtl/mc_main_control.sv - multi-cycle MIPS main control FSM
//
// Sequences each instruction through fetch/decode/execute/memory/writeback and
// drives the datapath mux selects, write enables and ALUOp.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   opcode              IR[31:26]; sampled only in DECODE and MEMADR
//   mem_ready           memory completes the current access this cycle
//   PCWrite, Branch     PC load (unconditional / qualified by ALU zero)
//   IorD                memory address select (0 = PC, 1 = ALUOut)
//   MemRead, MemWrite   memory requests
//   IRWrite             instruction register load
//   MemtoReg, RegDst    register file write-data / destination selects
//   RegWrite            register file write enable
//   ALUSrcA, ALUSrcB    ALU operand selects
//   PCSrc               PC source select
//   ALUOp               to ALUControl (00 add, 01 sub, 10 funct)
//   state               current state, for debug
//   illegal_op          one-cycle pulse in DECODE on an unsupported opcode
module mc_main_control #(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           PCWrite,
    output logic           Branch,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           MemtoReg,
    output logic           RegDst,
    output logic           RegWrite,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     PCSrc,
    output logic [1:0]     ALUOp,
    output logic [STW-1:0] state,
    output logic           illegal_op
);

    typedef enum logic [STW-1:0] {
        S_FETCH  = STW'(0),
        S_DECODE = STW'(1),
        S_MEMADR = STW'(2),
        S_MEMRD  = STW'(3),
        S_MEMWB  = STW'(4),
        S_MEMWR  = STW'(5),
        S_EXEC   = STW'(6),
        S_ALUWB  = STW'(7),
        S_BRANCH = STW'(8),
        S_ADDIEX = STW'(9),
        S_ADDIWB = STW'(10),
        S_JUMP   = STW'(11)
    } state_t;

    localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);

    // Held as a plain vector so encodings 12-15 are representable and recoverable.
    logic [STW-1:0] r_state;
    logic [STW-1:0] w_next;

    logic       w_pc_write, w_branch, w_iord, w_mem_read, w_mem_write, w_ir_write;
    logic       w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a, w_illegal;
    logic [1:0] w_alu_src_b, w_pc_src, w_alu_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = S_FETCH;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_dst    = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_pc_src     = 2'b00;
        w_alu_op     = 2'b00;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                // IR and PC+4 are only committed on the cycle the fetch completes.
                w_ir_write  = mem_ready;
                w_pc_write  = mem_ready;
                w_next      = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                case (opcode)
                    OP_R:    w_next = S_EXEC;
                    OP_LW:   w_next = S_MEMADR;
                    OP_SW:   w_next = S_MEMADR;
                    OP_BEQ:  w_next = S_BRANCH;
                    OP_ADDI: w_next = S_ADDIEX;
                    OP_J:    w_next = S_JUMP;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                if (opcode == OP_LW) begin
                    w_next = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                w_next     = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                w_next      = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b01;
                w_branch    = 1'b1;
                w_pc_src    = 2'b01;
            end
            S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
            end
            S_JUMP: begin
                w_pc_write = 1'b1;
                w_pc_src   = 2'b10;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset gates every output combinationally so nothing partial leaks out
    // while rst_n is low, regardless of the state decode.
    assign PCWrite    = rst_n & w_pc_write;
    assign Branch     = rst_n & w_branch;
    assign IorD       = rst_n & w_iord;
    assign MemRead    = rst_n & w_mem_read;
    assign MemWrite   = rst_n & w_mem_write;
    assign IRWrite    = rst_n & w_ir_write;
    assign MemtoReg   = rst_n & w_mem_to_reg;
    assign RegDst     = rst_n & w_reg_dst;
    assign RegWrite   = rst_n & w_reg_write;
    assign ALUSrcA    = rst_n & w_alu_src_a;
    assign ALUSrcB    = {2{rst_n}} & w_alu_src_b;
    assign PCSrc      = {2{rst_n}} & w_pc_src;
    assign ALUOp      = {2{rst_n}} & w_alu_op;
    assign illegal_op = rst_n & w_illegal;
    assign state      = {STW{rst_n}} & r_state;

endmodule

// File: tb/tb_mc_main_control.sv
// tb/tb_mc_main_control.sv - directed scoreboard bench for mc_main_control
module tb_mc_main_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, PCSrc, ALUOp;
    logic [3:0] state;

    always #5 clk = ~clk;

    mc_main_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp), .state(state),
        .illegal_op(illegal_op)
    );

    typedef struct {
        logic [3:0]  st;
        logic [16:0] o;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Order: PCWrite Branch IorD MemRead MemWrite IRWrite MemtoReg RegDst
    //        RegWrite ALUSrcA ALUSrcB[2] PCSrc[2] ALUOp[2] illegal_op
    function automatic logic [16:0] exp_out(input logic rstn, input logic [3:0] s,
                                            input logic rdy, input logic [5:0] op);
        logic pcw = 0, br = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0;
        logic rdst = 0, rw = 0, sa = 0, ill = 0;
        logic [1:0] sb = 0, pcs = 0, aop = 0;
        if (rstn) begin
            case (s)
                4'd0:  begin mrd = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
                4'd1:  begin
                    sb  = 2'b11;
                    ill = !(op inside {6'b000000, 6'b100011, 6'b101011,
                                       6'b000100, 6'b001000, 6'b000010});
                end
                4'd2:  begin sa = 1; sb = 2'b10; end
                4'd3:  begin mrd = 1; iord = 1; end
                4'd4:  begin rw = 1; m2r = 1; end
                4'd5:  begin mwr = 1; iord = 1; end
                4'd6:  begin sa = 1; aop = 2'b10; end
                4'd7:  begin rw = 1; rdst = 1; end
                4'd8:  begin sa = 1; aop = 2'b01; br = 1; pcs = 2'b01; end
                4'd9:  begin sa = 1; sb = 2'b10; end
                4'd10: begin rw = 1; end
                4'd11: begin pcw = 1; pcs = 2'b10; end
                default: ;
            endcase
        end
        return {pcw, br, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, pcs, aop, ill};
    endfunction

    function automatic logic [16:0] obs_out();
        return {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUOp, illegal_op};
    endfunction

    task automatic check_front();
        exp_t e;
        logic [16:0] o;
        e = exp_q.pop_front();
        o = obs_out();
        n_total++;
        assert (state === e.st) n_pass++;
        else $error("FAIL %s.state obs=%0d exp=%0d", e.tag, state, e.st);
        n_total++;
        assert (o === e.o) n_pass++;
        else $error("FAIL %s.outs obs=%05h exp=%05h", e.tag, o, e.o);
    endtask

    // One cycle: drive inputs just after the falling edge, push expectation,
    // compare 1 time unit later, then advance to the next falling edge.
    task automatic step(input string tag, input logic rstn, input logic rdy,
                        input logic [5:0] op, input logic [3:0] es);
        exp_t e;
        rst_n     = rstn;
        mem_ready = rdy;
        opcode    = op;
        e.st  = rstn ? es : 4'd0;
        e.o   = exp_out(rstn, es, rdy, op);
        e.tag = tag;
        exp_q.push_back(e);
        #1;
        check_front();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'b0;
        @(negedge clk);
        step("rst0", 0, 1, 6'b000000, 0);
        step("rst1", 0, 1, 6'b000000, 0);

        // R-type 0,1,6,7,0
        step("r_fetch", 1, 1, 6'b000000, 0);
        step("r_dec",   1, 1, 6'b000000, 1);
        step("r_exec",  1, 1, 6'b000000, 6);
        step("r_wb",    1, 1, 6'b000000, 7);

        // reset mid-instruction (lands in EXEC then aborted)
        step("mid_f",   1, 1, 6'b000000, 0);
        step("mid_d",   1, 1, 6'b000000, 1);
        step("mid_r0",  0, 1, 6'b000000, 0);
        step("mid_r1",  0, 1, 6'b000000, 0);
        step("mid_r2",  0, 1, 6'b000000, 0);
        step("rel",     1, 0, 6'b000000, 0);

        // lw with two wait cycles in MEMRD: 0,1,2,3,3,3,4,0
        step("lw_f",    1, 1, 6'b100011, 0);
        step("lw_d",    1, 1, 6'b100011, 1);
        step("lw_adr",  1, 1, 6'b100011, 2);
        step("lw_rd0",  1, 0, 6'b111111, 3);
        step("lw_rd1",  1, 0, 6'b000000, 3);
        step("lw_rd2",  1, 1, 6'b000100, 3);
        step("lw_wb",   1, 1, 6'b100011, 4);

        // sw with one wait in MEMWR: 0,1,2,5,5,0
        step("sw_f",    1, 1, 6'b101011, 0);
        step("sw_d",    1, 1, 6'b101011, 1);
        step("sw_adr",  1, 1, 6'b101011, 2);
        step("sw_wr0",  1, 0, 6'b000000, 5);
        step("sw_wr1",  1, 1, 6'b000000, 5);

        // beq 0,1,8,0
        step("beq_f",   1, 1, 6'b000100, 0);
        step("beq_d",   1, 1, 6'b000100, 1);
        step("beq_br",  1, 1, 6'b000100, 8);

        // j 0,1,11,0
        step("j_f",     1, 1, 6'b000010, 0);
        step("j_d",     1, 1, 6'b000010, 1);
        step("j_jmp",   1, 1, 6'b000010, 11);

        // addi 0,1,9,10,0
        step("ad_f",    1, 1, 6'b001000, 0);
        step("ad_d",    1, 1, 6'b001000, 1);
        step("ad_ex",   1, 1, 6'b001000, 9);
        step("ad_wb",   1, 1, 6'b001000, 10);

        // fetch stall: four wait cycles, then a single-cycle IRWrite/PCWrite
        for (int i = 0; i < 4; i++) step("fwait", 1, 0, 6'b000000, 0);
        step("fdone",   1, 1, 6'b111111, 0);

        // illegal opcode
        step("ill_d",   1, 1, 6'b111111, 1);
        step("ill_f",   1, 0, 6'b111111, 0);

        // unused encoding recovers to FETCH
        begin
            exp_t e;
            mem_ready = 1'b0;
            force dut.r_state = 4'd13;
            e.st = 4'd13; e.o = 17'd0; e.tag = "st13";
            exp_q.push_back(e);
            #1;
            check_front();
            release dut.r_state;
            @(negedge clk);
        end
        step("rec_f",   1, 0, 6'b000000, 0);

        n_total++;
        assert (exp_q.size() == 0) n_pass++;
        else $error("FAIL sb_empty obs=%0d exp=0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
